// File: rtl/gdp_feeder.sv
// Observation feeder for a Gaussian-distance scoring stage: buffers one vector, then streams
// per-state COMP/DRAIN/KEY slots with parameter-memory reads and 2-cycle-lagged registered operands.
module gdp_feeder #(
    parameter int NUM_COMP   = 8,
    parameter int NUM_STATES = 16,
    parameter int DRAIN      = 3,
    parameter int ADDR_W     = 12,
    parameter int STATE_W    = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               obs_valid,
    input  logic [15:0]        obs_data,
    output logic               obs_ready,
    input  logic               start,
    output logic               param_rd,
    output logic [ADDR_W-1:0]  param_addr,
    input  logic [31:0]        param_data,
    output logic [15:0]        x,
    output logic [15:0]        omega,
    output logic [15:0]        mean,
    output logic [15:0]        k,
    output logic               first_calc,
    output logic               last_calc,
    output logic [STATE_W-1:0] state_id,
    output logic               busy,
    output logic               done
);

    localparam int S      = NUM_COMP + DRAIN + 1;
    localparam int SLOT_W = $clog2(S);
    localparam int PTR_W  = (NUM_COMP > 1) ? $clog2(NUM_COMP) : 1;

    localparam logic [SLOT_W-1:0]  NC_SLOT  = SLOT_W'(NUM_COMP);
    localparam logic [SLOT_W-1:0]  KEY_SLOT = SLOT_W'(NUM_COMP + DRAIN);
    localparam logic [PTR_W-1:0]   LAST_PTR = PTR_W'(NUM_COMP - 1);
    localparam logic [ADDR_W-1:0]  STRIDE   = ADDR_W'(NUM_COMP + 1);
    localparam logic [ADDR_W-1:0]  KEY_OFS  = ADDR_W'(NUM_COMP);
    localparam logic [STATE_W-1:0] LAST_SID = STATE_W'(NUM_STATES - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_LOADED = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_FLUSH  = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [STATE_W-1:0] sid_q, sid_d;
    logic               flush_q, flush_d;
    logic               done_q, done_d;

    logic [15:0]        buf_q [0:(1 << PTR_W) - 1];

    logic               p1_comp_q, p1_key_q, p1_first_q;
    logic [PTR_W-1:0]   p1_c_q;
    logic [STATE_W-1:0] p1_sid_q;

    logic [15:0]        x_q, omega_q, mean_q, k_q;
    logic               first_q, last_q;
    logic [STATE_W-1:0] state_id_q;

    logic accept, in_run, is_comp, is_key;

    assign obs_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept    = obs_valid && obs_ready;
    assign in_run    = (state_q == ST_RUN);
    assign is_comp   = in_run && (slot_q < NC_SLOT);
    assign is_key    = in_run && (slot_q == KEY_SLOT);
    assign busy      = in_run || (state_q == ST_FLUSH);
    assign done      = done_q;

    // DRAIN slots fall through to base+slot; the address is unused there.
    assign param_rd   = is_comp || is_key;
    assign param_addr = !in_run ? '0 :
                        is_key  ? base_q + KEY_OFS :
                                  base_q + ADDR_W'(slot_q);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        slot_d   = slot_q;
        base_d   = base_q;
        sid_d    = sid_q;
        flush_d  = flush_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (accept) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_PTR) begin
                        state_d  = ST_LOADED;
                        wr_ptr_d = '0;
                    end
                end
            end
            ST_LOADED: begin
                if (start) begin
                    state_d = ST_RUN;
                    slot_d  = '0;
                    base_d  = '0;
                    sid_d   = '0;
                end
            end
            ST_RUN: begin
                if (slot_q == KEY_SLOT) begin
                    slot_d = '0;
                    base_d = base_q + STRIDE;
                    sid_d  = sid_q + STATE_W'(1);
                    if (sid_q == LAST_SID) begin
                        state_d = ST_FLUSH;
                        flush_d = 1'b0;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            ST_FLUSH: begin
                flush_d = 1'b1;
                if (flush_q) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            slot_q   <= '0;
            base_q   <= '0;
            sid_q    <= '0;
            flush_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            slot_q   <= slot_d;
            base_q   <= base_d;
            sid_q    <= sid_d;
            flush_q  <= flush_d;
            done_q   <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[wr_ptr_q] <= obs_data;
        end
    end

    // Stage 1 follows the issue cycle, stage 2 samples the memory word that arrives with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_comp_q  <= 1'b0;
            p1_key_q   <= 1'b0;
            p1_first_q <= 1'b0;
            p1_c_q     <= '0;
            p1_sid_q   <= '0;
            x_q        <= '0;
            omega_q    <= '0;
            mean_q     <= '0;
            k_q        <= '0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            state_id_q <= '0;
        end else begin
            p1_comp_q  <= is_comp;
            p1_key_q   <= is_key;
            p1_first_q <= is_comp && (slot_q == '0);
            p1_c_q     <= is_comp ? PTR_W'(slot_q) : '0;
            p1_sid_q   <= in_run ? sid_q : '0;
            x_q        <= p1_comp_q ? buf_q[p1_c_q] : '0;
            omega_q    <= p1_comp_q ? param_data[31:16] : '0;
            mean_q     <= p1_comp_q ? param_data[15:0] : '0;
            k_q        <= p1_key_q ? param_data[31:16] : '0;
            first_q    <= p1_first_q;
            last_q     <= p1_key_q;
            state_id_q <= p1_sid_q;
        end
    end

    assign x          = x_q;
    assign omega      = omega_q;
    assign mean       = mean_q;
    assign k          = k_q;
    assign first_calc = first_q;
    assign last_calc  = last_q;
    assign state_id   = state_id_q;

endmodule

// File: tb/tb_gdp_feeder.sv
// Directed-plus-random bench for gdp_feeder: a main instance (2 comps, 2 states, drain 3)
// and a minimal instance (1 comp, 3 states, no drain) checked against a slot-level model.
module tb_gdp_feeder;

    localparam int NC  = 2;
    localparam int NS  = 2;
    localparam int DR  = 3;
    localparam int S   = NC + DR + 1;
    localparam int TOT = NS * S;
    localparam int BTOT = 3 * 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, obs_valid, start, obs_ready, param_rd;
    logic [15:0] obs_data;
    logic [11:0] param_addr;
    logic [31:0] param_data;
    logic [15:0] x, omega, mean, k;
    logic        first_calc, last_calc, busy, done;
    logic [7:0]  state_id;

    logic        b_obs_valid, b_start, b_obs_ready, b_param_rd;
    logic [15:0] b_obs_data;
    logic [11:0] b_param_addr;
    logic [31:0] b_param_data;
    logic [15:0] b_x, b_omega, b_mean, b_k;
    logic        b_first, b_last, b_busy, b_done;
    logic [7:0]  b_state_id;

    int          errs = 0;
    int          checks = 0;
    logic [15:0] vec [NC];
    logic [31:0] mem [0:63];
    logic [31:0] bmem [0:15];
    logic        prev_rd, b_prev_rd;
    logic [11:0] prev_addr, b_prev_addr;

    gdp_feeder #(.NUM_COMP(NC), .NUM_STATES(NS), .DRAIN(DR), .ADDR_W(12), .STATE_W(8)) u_dut (
        .clk(clk), .reset(reset), .obs_valid(obs_valid), .obs_data(obs_data), .obs_ready(obs_ready),
        .start(start), .param_rd(param_rd), .param_addr(param_addr), .param_data(param_data),
        .x(x), .omega(omega), .mean(mean), .k(k), .first_calc(first_calc), .last_calc(last_calc),
        .state_id(state_id), .busy(busy), .done(done)
    );

    gdp_feeder #(.NUM_COMP(1), .NUM_STATES(3), .DRAIN(0), .ADDR_W(12), .STATE_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .obs_valid(b_obs_valid), .obs_data(b_obs_data), .obs_ready(b_obs_ready),
        .start(b_start), .param_rd(b_param_rd), .param_addr(b_param_addr), .param_data(b_param_data),
        .x(b_x), .omega(b_omega), .mean(b_mean), .k(b_k), .first_calc(b_first), .last_calc(b_last),
        .state_id(b_state_id), .busy(b_busy), .done(b_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model answers the read issued in the previous cycle; idle cycles carry junk.
    task automatic tick();
        @(posedge clk);
        #1;
        param_data   = prev_rd ? mem[prev_addr[5:0]] : $urandom();
        b_param_data = b_prev_rd ? bmem[b_prev_addr[3:0]] : $urandom();
        prev_rd      = param_rd;
        prev_addr    = param_addr;
        b_prev_rd    = b_param_rd;
        b_prev_addr  = b_param_addr;
    endtask

    task automatic check_reset_vals();
        chk("rst_obs_ready", obs_ready, 1);
        chk("rst_param_rd", param_rd, 0);
        chk("rst_param_addr", param_addr, 0);
        chk("rst_x", x, 0);
        chk("rst_omega", omega, 0);
        chk("rst_mean", mean, 0);
        chk("rst_k", k, 0);
        chk("rst_first", first_calc, 0);
        chk("rst_last", last_calc, 0);
        chk("rst_state_id", state_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
    endtask

    task automatic randomize_env();
        for (int i = 0; i < 64; i++) mem[i] = $urandom();
        for (int i = 0; i < NC; i++) vec[i] = 16'($urandom());
    endtask

    task automatic load_vec();
        for (int i = 0; i < NC; i++) begin
            obs_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("load_gap_ready", obs_ready, 1);
            end
            chk("load_ready", obs_ready, 1);
            obs_valid = 1'b1;
            obs_data  = vec[i];
            tick();
        end
        obs_valid = 1'b0;
        chk("loaded_ready", obs_ready, 0);
    endtask

    // Expects the DUT in LOADED; optionally aborts with a reset at cycle abort_n.
    task automatic run_pass(input bit hold, input int abort_n);
        int s, j, o, a;
        logic [15:0] ex_x, ex_om, ex_mn, ex_k;
        logic ex_f, ex_l;
        int ex_sid;
        start     = 1'b1;
        obs_valid = hold;
        for (int n = 1; n <= TOT + 3; n++) begin
            tick();
            if (n == 2) start = 1'b0;
            obs_data = 16'($urandom());
            if (n - 1 < TOT) begin
                s = (n - 1) / S;
                j = (n - 1) % S;
                chk("param_rd", param_rd, (j < NC || j == S - 1));
                if (j < NC || j == S - 1)
                    chk("param_addr", param_addr, s * (NC + 1) + ((j < NC) ? j : NC));
            end
            chk("busy", busy, n <= TOT + 2);
            chk("done", done, n == TOT + 3);
            chk("pass_obs_ready", obs_ready, n == TOT + 3);
            o = n - 3;
            ex_x = 0; ex_om = 0; ex_mn = 0; ex_k = 0; ex_f = 0; ex_l = 0; ex_sid = 0;
            if (o >= 0 && o < TOT) begin
                s = o / S;
                j = o % S;
                a = s * (NC + 1) + ((j < NC) ? j : NC);
                ex_sid = s;
                if (j < NC) begin
                    ex_x  = vec[j];
                    ex_om = mem[a][31:16];
                    ex_mn = mem[a][15:0];
                    ex_f  = (j == 0);
                end else if (j == S - 1) begin
                    ex_k = mem[a][31:16];
                    ex_l = 1'b1;
                end
            end
            chk("x", x, ex_x);
            chk("omega", omega, ex_om);
            chk("mean", mean, ex_mn);
            chk("k", k, ex_k);
            chk("first_calc", first_calc, ex_f);
            chk("last_calc", last_calc, ex_l);
            chk("state_id", state_id, ex_sid);
            if (n == abort_n) begin
                reset = 1'b1; obs_valid = 1'b0; start = 1'b0;
                tick();
                check_reset_vals();
                reset = 1'b0;
                for (int m = 0; m < 5; m++) begin
                    tick();
                    chk("abort_done", done, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_flags", {first_calc, last_calc}, 0);
                end
                return;
            end
        end
        obs_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] bword;
        int o;
        reset = 1'b1; obs_valid = 1'b0; start = 1'b0; obs_data = '0; param_data = '0;
        b_obs_valid = 1'b0; b_start = 1'b0; b_obs_data = '0; b_param_data = '0;
        prev_rd = 1'b0; prev_addr = '0; b_prev_rd = 1'b0; b_prev_addr = '0;
        tick();
        tick();
        check_reset_vals();
        reset = 1'b0;
        tick();

        // Reference vector and memory image
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0] = 32'h0001_0002; mem[1] = 32'h0003_0004; mem[2] = 32'h0009_0000;
        mem[3] = 32'h0006_0008; mem[4] = 32'h000A_000C; mem[5] = 32'h000B_0000;
        vec[0] = 16'd5; vec[1] = 16'd7;
        load_vec();
        run_pass(1'b0, 0);

        // start during LOAD is ignored; obs_valid held high through the pass
        randomize_env();
        obs_valid = 1'b1; obs_data = vec[0];
        tick();
        obs_valid = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("early_start_busy", busy, 0);
        chk("early_start_ready", obs_ready, 1);
        tick();
        chk("early_start_busy2", busy, 0);
        obs_valid = 1'b1; obs_data = vec[1];
        tick();
        obs_valid = 1'b0;
        chk("second_word_ready", obs_ready, 0);
        run_pass(1'b1, 0);

        // Reset during state 1's first DRAIN issue, then a clean pass
        randomize_env();
        load_vec();
        run_pass(1'b0, S + NC + 1);
        randomize_env();
        load_vec();
        run_pass(1'b0, 0);

        for (int r = 0; r < 3; r++) begin
            randomize_env();
            load_vec();
            run_pass(1'($urandom_range(0, 1)), 0);
        end

        // Single-component, zero-drain instance
        for (int i = 0; i < 16; i++) bmem[i] = $urandom();
        bword = 16'($urandom());
        chk("b_ready", b_obs_ready, 1);
        b_obs_valid = 1'b1; b_obs_data = bword;
        tick();
        b_obs_valid = 1'b0;
        chk("b_loaded_ready", b_obs_ready, 0);
        b_start = 1'b1;
        for (int n = 1; n <= BTOT + 3; n++) begin
            tick();
            b_start = 1'b0;
            o = n - 3;
            chk("b_excl", b_first && b_last, 0);
            chk("b_done", b_done, n == BTOT + 3);
            if (n - 1 < BTOT) chk("b_addr", b_param_addr, n - 1);
            if (o >= 0 && o < BTOT) begin
                chk("b_first", b_first, (o % 2) == 0);
                chk("b_last", b_last, (o % 2) == 1);
                chk("b_x", b_x, ((o % 2) == 0) ? bword : 16'd0);
                chk("b_mean", b_mean, ((o % 2) == 0) ? bmem[o][15:0] : 16'd0);
                chk("b_k", b_k, ((o % 2) == 1) ? bmem[o][31:16] : 16'd0);
                chk("b_state_id", b_state_id, o / 2);
            end else begin
                chk("b_idle_flags", {b_first, b_last}, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/gdp_feeder.md
GDP_FEEDER -- requirements
Module: gdp_feeder

Interface
REQ-001 Parameter NUM_COMP, default 8, observation components per vector (>=1).
REQ-002 Parameter NUM_STATES, default 16, states scored per pass (>=1).
REQ-003 Parameter DRAIN, default 3, idle slots between the last component and the k slot; matches the downstream GDP pipeline depth.
REQ-004 Parameters ADDR_W, default 12, and STATE_W, default 8, are the parameter-memory address width and the state tag width.
REQ-005 Port list, one per line:
  clk  in  1  sole clock; every register updates on its rising edge
  reset  in  1  synchronous, active-high
  obs_valid  in  1  observation word valid
  obs_data  in  16  observation component
  obs_ready  out  1  feeder accepts an observation word
  start  in  1  begin a scoring pass
  param_rd  out  1  parameter memory read strobe
  param_addr  out  ADDR_W  parameter memory word address
  param_data  in  32  read data, valid exactly 1 cycle after param_rd
  x, omega, mean, k  out  16 each  operands to the GDP stage
  first_calc, last_calc  out  1 each  GDP control flags
  state_id  out  STATE_W  state tag of the current slot
  busy  out  1  pass in progress
  done  out  1  one-cycle end-of-pass pulse

Function
REQ-006 The parameter memory layout per state SHALL be NUM_COMP words of {omega[31:16], mean[15:0]}, then one word with k in [31:16]; state s base = s*(NUM_COMP+1), computed by an accumulating counter (no multiplier).
REQ-007 The FSM SHALL have the states IDLE, LOAD, LOADED, RUN and FLUSH.
REQ-008 In IDLE or LOAD, obs_ready=1; each cycle with obs_valid&&obs_ready SHALL write obs_data to buffer[wr_ptr] and increment wr_ptr.
REQ-009 On the NUM_COMP-th accepted word, the FSM SHALL go to LOADED with obs_ready=0; wr_ptr wraps to 0.
REQ-010 start SHALL be honoured only in LOADED and ignored in every other state.
REQ-011 Once honoured, the FSM enters RUN and busy=1 from the next cycle.
REQ-012 RUN SHALL issue per state, back-to-back with no inter-state gap, S=NUM_COMP+DRAIN+1 slots: COMP c=0..NUM_COMP-1, DRAIN, KEY.
REQ-013 A COMP slot SHALL assert param_rd with param_addr=base+c.
REQ-014 A KEY slot SHALL assert param_rd with param_addr=base+NUM_COMP.
REQ-015 A DRAIN slot SHALL hold param_rd=0; in that slot param_addr is don't-care.
REQ-016 All GDP-side outputs SHALL be registered and lag their slot's issue cycle by exactly 2 cycles.
REQ-017 COMP output: x=buffer[c], omega=param_data[31:16], mean=param_data[15:0], k=0; first_calc=1 only for c=0.
REQ-018 DRAIN output: x=omega=mean=k=0 and both flags 0, so the downstream accumulator adds zero.
REQ-019 KEY output: k=param_data[31:16], x=omega=mean=0, last_calc=1.
REQ-020 state_id SHALL tag every output slot with its state index, 0..NUM_STATES-1.
REQ-021 After the final KEY slot is issued, the FSM SHALL enter FLUSH for 2 cycles.
REQ-022 done SHALL pulse 1 cycle after the final last_calc output.
REQ-023 In the done cycle, busy=0 and the FSM returns to IDLE with obs_ready=1, so a new vector loads for the next pass.
REQ-024 If obs_valid is asserted in LOADED, RUN or FLUSH, the word SHALL be ignored and not stored.
REQ-025 When NUM_COMP=1, first_calc and last_calc SHALL never coincide; the KEY slot is always separate.

Reset
REQ-026 While reset=1 at a clock edge, the FSM SHALL go to IDLE with wr_ptr=0, the buffer contents don't-care, and the in-flight output pipeline cleared.
REQ-027 The reset values SHALL be: obs_ready=1; param_rd=0; param_addr=0; x=omega=mean=k=0; first_calc=last_calc=0; state_id=0; busy=0; done=0.
REQ-028 A reset mid-load or mid-pass SHALL abandon the operation; no done pulse and no further flags are produced.

Verification
REQ-029 NUM_COMP=2, NUM_STATES=2, DRAIN=3; load 5,7; memory {1,2},{3,4},{9,0}, then {6,8},{10,12},{11,0}; start. Required: addresses 0,1,2,3,4,5; KEY at state 0 outputs k=9, KEY at state 1 outputs k=11; first_calc in cycles with x=5; done once.
REQ-030 Per-state slot count: 6 slots per state with no gap between state 0's KEY and state 1's COMP0.
REQ-031 Output lag: a COMP0 issue at cycle T yields first_calc=1 at T+2.
REQ-032 start pulsed during LOAD after 1 word -> ignored; a second word then start -> pass runs.
REQ-033 obs_valid held high through the pass -> buffer unchanged; x values are identical to the loaded vector.
REQ-034 reset asserted during state 1 DRAIN -> next cycle: all outputs at reset values, no done; a fresh load and pass complete normally.
REQ-035 NUM_COMP=1, DRAIN=0 -> first_calc and last_calc alternate on successive cycles and are never both 1.
